// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, debounces extlock and gates the
// downstream system reset, retrying on lock timeout and latching a fault when retries run out.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked_ok,
  output logic       lock_lost,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int unsigned MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT     = {CW{1'b1}};
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [3:0]    next_retry;
  logic          sync1;
  logic          lock_s;

  // Next-state and retry bookkeeping; lock_s is checked before the timeout so it wins a tie
  always_comb begin
    next_state = state;
    next_retry = retry_cnt;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) begin
          next_state = WAIT_LOCK;
        end else begin
          next_state = RESET_PLL;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          next_state = STABLE;
        end else if (cnt == TO_LAST) begin
          if (retry_cnt >= RETRY_MAX) begin
            next_state = FAULT;
          end else begin
            next_state = RESET_PLL;
            next_retry = retry_cnt + 4'd1;
          end
        end else begin
          next_state = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          next_state = RUN;
          next_retry = 4'd0;
        end else begin
          next_state = STABLE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          next_state = LOST;
        end else begin
          next_state = RUN;
        end
      end
      LOST:    next_state = RESET_PLL;
      FAULT:   next_state = FAULT;
      default: next_state = RESET_PLL;
    endcase
  end

  // State, counter, synchronizer and outputs; outputs decode the state being entered
  always_ff @(posedge refclk) begin
    if (reset) begin
      state     <= RESET_PLL;
      cnt       <= {CW{1'b0}};
      retry_cnt <= 4'd0;
      sync1     <= 1'b0;
      lock_s    <= 1'b0;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      locked_ok <= 1'b0;
      lock_lost <= 1'b0;
      fault     <= 1'b0;
    end else begin
      sync1     <= extlock;
      lock_s    <= sync1;
      state     <= next_state;
      retry_cnt <= next_retry;
      if (next_state != state) begin
        cnt <= {CW{1'b0}};
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= cnt;
      end
      case (next_state)
        RESET_PLL: begin
          pll_reset <= 1'b1; sys_reset <= 1'b1; locked_ok <= 1'b0; lock_lost <= 1'b0; fault <= 1'b0;
        end
        WAIT_LOCK, STABLE: begin
          pll_reset <= 1'b0; sys_reset <= 1'b1; locked_ok <= 1'b0; lock_lost <= 1'b0; fault <= 1'b0;
        end
        RUN: begin
          pll_reset <= 1'b0; sys_reset <= 1'b0; locked_ok <= 1'b1; lock_lost <= 1'b0; fault <= 1'b0;
        end
        LOST: begin
          pll_reset <= 1'b0; sys_reset <= 1'b1; locked_ok <= 1'b0; lock_lost <= 1'b1; fault <= 1'b0;
        end
        FAULT: begin
          pll_reset <= 1'b1; sys_reset <= 1'b1; locked_ok <= 1'b0; lock_lost <= 1'b0; fault <= 1'b1;
        end
        default: begin
          pll_reset <= 1'b1; sys_reset <= 1'b1; locked_ok <= 1'b0; lock_lost <= 1'b0; fault <= 1'b0;
        end
      endcase
    end
  end

endmodule
